// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multi-digit time-multiplexed seven-segment driver
// Values convert sequentially (double-dabble or hex) into a buffer that is replaced atomically at commit.
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 32,
  parameter int REFRESH_DIV = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VALUE_W-1:0]  value_i,
  input  logic                valid_i,
  input  logic                hex_mode_i,
  input  logic                load_i,
  output logic                busy_o,
  output logic                overflow_o,
  output logic [6:0]          seg_o,
  output logic [DIGITS-1:0]   dig_en_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] DASH  = 7'b0000001;
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [7*DIGITS-1:0] BUF_INV = (7*DIGITS)'(DASH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                  state_q;
  logic [VALUE_W-1:0]      val_q;
  logic                    valid_q, hex_q, busy_q, ovf_q, dovf_q;
  logic [BW-1:0]           bcd_q, bcd_adj;
  logic [CW-1:0]           shcnt_q;
  logic [7*DIGITS-1:0]     buf_q, buf_c;
  logic                    ovf_c;

  logic [REFRESH_DIV-1:0]  rcnt_q, rcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       dig_q, dig_d;

  logic [BW+VALUE_W-1:0]   wide;
  logic [BW-1:0]           nibs;
  logic [3:0]              nib;
  logic                    seen;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // Buffer image built from the captured/converted value; walking down from the top digit finds leading zeros.
  always_comb begin
    wide  = {{BW{1'b0}}, val_q};
    nibs  = hex_q ? wide[BW-1:0] : bcd_q;
    ovf_c = valid_q && (hex_q ? |(wide >> BW) : dovf_q);
    seen  = 1'b0;
    nib   = 4'd0;
    buf_c = '0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      nib = nibs[4*k +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (!valid_q)             buf_c[7*k +: 7] = (k == 0) ? DASH : BLANK;
      else if (ovf_c)           buf_c[7*k +: 7] = DASH;
      else if (seen || k == 0)  buf_c[7*k +: 7] = seg7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      valid_q <= 1'b0;
      hex_q   <= 1'b0;
      bcd_q   <= '0;
      dovf_q  <= 1'b0;
      shcnt_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      buf_q   <= BUF_INV;
    end else begin
      case (state_q)
        S_IDLE: if (load_i) begin
          val_q   <= value_i;
          valid_q <= valid_i;
          hex_q   <= hex_mode_i;
          bcd_q   <= '0;
          dovf_q  <= 1'b0;
          shcnt_q <= '0;
          busy_q  <= 1'b1;
          state_q <= (valid_i && !hex_mode_i) ? S_SHIFT : S_COMMIT;
        end
        S_SHIFT: begin
          bcd_q   <= {bcd_adj[BW-2:0], val_q[VALUE_W-1]};
          dovf_q  <= dovf_q | bcd_adj[BW-1];
          val_q   <= val_q << 1;
          shcnt_q <= shcnt_q + 1'b1;
          if (shcnt_q == CW'(VALUE_W-1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          buf_q   <= buf_c;
          ovf_q   <= ovf_c;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs follow the next counter value, so counter==0 is the blanked first clock of every slot.
  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (&rcnt_q) idx_d = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
    seg_d  = '0;
    dig_d  = '0;
    if (rcnt_d != '0) begin
      seg_d        = buf_q[7*idx_d +: 7];
      dig_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= '0;
      dig_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;
  assign seg_o      = seg_q;
  assign dig_en_o   = dig_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised multi-digit, time-multiplexed seven-segment display driver, the successor to the single-digit `seven_seg` driver. It accepts a binary value with a load strobe and converts it to decimal sequentially (double-dabble) or displays it as hex. The result is held in a display buffer that is updated atomically, and one digit at a time is scanned onto a shared segment bus. It sits between the stack processor's top-of-stack/status signals and the board pins. Because the buffer is only replaced when conversion completes, a half-updated value is never displayed.

## Interface
- `DIGITS`, default 4: number of digits, ≥1.
- `VALUE_W`, default 32: width of `value`, ≥1.
- `REFRESH_DIV`, default 14: each digit slot lasts 2^REFRESH_DIV clocks, ≥2.
- `clk` input, 1 bit: clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `value` input, VALUE_W bits: number to display.
- `valid` input, 1 bit: 0 means show "invalid" instead of `value`.
- `hex_mode` input, 1 bit: 1 selects hex display; 0 selects decimal.
- `load` input, 1 bit: capture strobe for `value`, `valid` and `hex_mode`.
- `busy` output, 1 bit: conversion in progress; `load` is ignored while high.
- `overflow` output, 1 bit: the last committed value did not fit in DIGITS digits.
- `seg` output, 7 bits: {A,B,C,D,E,F,G}, active-high, registered.
- `dig_en` output, DIGITS bits: one-hot digit enable, bit 0 is the rightmost digit, active-high, registered.

## Operation
- **Accept.** A load is accepted when `load && !busy`. Inputs are captured on that edge and `busy` rises on the same edge.
- **Invalid path** (`valid=0`, `hex_mode` ignored):
  - Commit the invalid pattern: digit 0 shows dash `0000001`, all other digits blank `0000000`.
  - `overflow` is 0.
- **Hex path:**
  - Digit k = `value[4k+3:4k]`, zero-extended beyond VALUE_W.
  - If any bit at or above 4·DIGITS is set, set `overflow`.
- **Decimal path:**
  - Double-dabble over a 4·DIGITS-bit BCD register, one bit per cycle, MSB first, for VALUE_W shift cycles.
  - Before each shift, add 3 to every BCD digit that is ≥5.
  - If a 1 is ever shifted out of the top BCD digit, set `overflow`.
- **Commit cycle.**
  - The display buffer and `overflow` are updated together, then `busy` falls.
  - If `overflow` is set, every digit shows dash.
- **Leading-zero suppression.** Digits above the most-significant nonzero digit are blank. Digit 0 always shows, so a value of 0 displays "0". This applies in both modes.
- **Segment codes:**
  - 0 `1111110`, 1 `0110000`, 2 `1101101`, 3 `1111001`, 4 `0110011`
  - 5 `1011011`, 6 `1011111`, 7 `1110000`, 8 `1111111`, 9 `1111011`
  - A `1110111`, b `0011111`, C `1001110`, d `0111101`, E `1001111`, F `1000111`
- **Scanner:**
  - A free-running REFRESH_DIV-bit counter drives the digit index, which advances 0→DIGITS-1→0 when the counter wraps.
  - The first clock of each slot is dead time: `dig_en`=0 and `seg`=0 (anti-ghosting).
  - For the remaining clocks of the slot, `dig_en` is one-hot at the index and `seg` shows that digit's code from the buffer.
  - The scanner never stalls for conversion; it reads the old buffer until commit.

## Timing
- **Reset values:**
  - `seg`=0, `dig_en`=0, `busy`=0, `overflow`=0.
  - Scan counter=0, index=0.
  - Buffer holds the invalid pattern (dash at digit 0).
- **Latency from the accepting edge E:**
  - Hex or invalid: commit at E+1; `busy` high exactly 1 cycle.
  - Decimal: shifts on E+1…E+VALUE_W, commit at E+VALUE_W+1; `busy` high VALUE_W+1 cycles.
- **Next load.** The earliest next accepted `load` is the cycle `busy` is low.
- **Display pickup.** A committed buffer appears on `seg` at the next non-dead clock of any slot, no later than the following clock edge.
- **Load while busy.** The load is dropped; there is no queueing.
- **Reset mid-conversion.** The conversion aborts immediately and all state returns to reset values.
- **Sizing corner.** With DIGITS·4 ≥ VALUE_W in hex mode, `overflow` is always 0.

## Test plan
Bench parameters: DIGITS=4, VALUE_W=16, REFRESH_DIV=3.
- **Reset.** Assert `rst_n`=0 mid-run → `seg`=0 and `dig_en`=0 immediately. After release, each slot of 8 clocks has 1 dead clock, then `dig_en` 0001 with `seg` `0000001`; `dig_en` 0010/0100/1000 with `seg` `0000000`.
- **Decimal 1234.** `load` with `value`=1234, `valid`=1, `hex_mode`=0 → `busy` high for 17 cycles. Digits 3..0 then show `0110000`, `1101101`, `1111001`, `0110011`; `overflow`=0.
- **Suppression.** `value`=7 → digit 0 `1110000`, digits 1–3 blank. `value`=0 → digit 0 `1111110`, rest blank.
- **Overflow vs hex.** Decimal 12345 → `overflow`=1, all digits `0000001`. Hex 0x3039 → digits 3..0 show 3,0,3,9, `overflow`=0.
- **Dropped load, invalid.** A second `load` pulsed while `busy` is ignored; the first value is displayed. `load` with `valid`=0 → dash at digit 0, others blank, `busy` high 1 cycle.
- **Reset mid-conversion.** `rst_n` pulsed low during a decimal conversion → `busy`=0 and the invalid pattern is shown. The next `load` converts correctly.
